cv32e40p_fault_monitor: RTL and testbench
=========================================

Name: cv32e40p_fault_monitor

Overview:
Downstream consumer of the fault flags produced by the TMR-hardened execution units (multiplier, ALU, etc.).
- Qualifies each unit's voter fault with that unit's result-valid.
- Keeps sticky status and saturating per-source event counters.
- Raises a one-cycle interrupt on each newly faulting source.
- Escalates persistent faults (same source, consecutive qualified cycles) to the controller as a recovery request with a req/ack handshake and a cooldown window.

Parameters:
N_SRC, 4, number of fault sources (bit i = hardened unit i; bit 1 = multiplier)
CNT_W, 8, width of each saturating fault-event counter
PERSIST_TH, 3, consecutive qualified faults on one source that trigger recovery (>=1)
COOL_CYC, 4, cycles after acknowledge during which escalation is suppressed (>=1)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
fault_i  input  N_SRC  per-source voter fault flag (e.g. mult_fault)
valid_i  input  N_SRC  per-source result consumed this cycle (unit ready & ex_ready)
clear_i  input  1  clear sticky bits and event counters
recover_ack_i  input  1  controller accepts recovery request
fault_sticky_o  output  N_SRC  sticky per-source fault status
fault_cnt_o  output  N_SRC*CNT_W  packed event counters, source i at [i*CNT_W +: CNT_W]
recover_req_o  output  1  recovery request, level until acked
recover_src_o  output  $clog2(N_SRC) (min 1)  source index that triggered the request
irq_o  output  1  one-cycle pulse on any sticky 0->1 transition

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). All state and outputs are registered.
- Reset values: sticky=0, counters=0, run counters=0, FSM=IDLE, recover_req_o=0, recover_src_o=0, irq_o=0.
- Reset asserted mid-request or mid-cooldown aborts immediately to these values.
- Qualified fault: q[i] = fault_i[i] & valid_i[i]. fault_i with valid_i low is ignored.
- sticky[i]:
  - set on q[i];
  - cleared by clear_i;
  - if clear_i and q[i] occur in the same cycle, the result is 1 (the event is not lost).
- cnt[i]:
  - +1 on q[i], saturating at 2^CNT_W-1 (no wrap);
  - clear_i sets it to 0;
  - clear_i together with q[i] gives 1.
- irq_o: registered pulse, high for exactly one cycle after any sticky bit goes 0->1.
  - Several bits rising together produce one pulse.
  - A bit already set produces no pulse.
- run[i], width $clog2(PERSIST_TH+1):
  - q[i] -> increment, saturating at PERSIST_TH;
  - valid_i[i] & !fault_i[i] -> 0;
  - !valid_i[i] -> hold;
  - frozen in REQ, forced to 0 on leaving REQ and throughout COOL.
  - clear_i does not affect run.
- FSM (enum IDLE, REQ, COOL):
  - IDLE: if any run[i]==PERSIST_TH after this edge's update -> REQ.
    - recover_src_o latches the lowest such index.
    - recover_req_o is high from the next cycle, i.e. one cycle after the PERSIST_TH-th qualified fault.
  - REQ: recover_req_o=1 and recover_src_o stable until a cycle with recover_ack_i=1, then -> COOL and recover_req_o=0 in the next cycle.
  - COOL: counter loads COOL_CYC-1 and decrements; at 0 -> IDLE.
    - sticky and cnt keep updating.
    - No escalation.
  - recover_ack_i outside REQ is ignored.
- sticky, cnt and irq_o operate identically in every FSM state.

Decomposition:
- Package: add fault_fsm_e (IDLE/REQ/COOL) to cv32e40p_pkg.
- Sub-module cv32e40p_fault_src_tracker, instantiated N_SRC times via generate. It holds sticky, cnt, run for one source, with inputs q, valid, fault, clear, run_clr, run_freeze.
- The top holds the FSM, lowest-index priority encoder, cooldown counter and irq edge detect.

Test Plan:
Defaults: N_SRC=4, CNT_W=8, PERSIST_TH=3, COOL_CYC=4.
1. Reset released with inputs 0 -> all outputs 0. Assert rst_n=0 while in REQ -> recover_req_o drops asynchronously; sticky=0000.
2. fault_i=0010, valid_i=0010 for 1 cycle -> sticky=0010, cnt1=1, irq_o pulses 1 cycle, recover_req_o stays 0. Repeat -> cnt1=2, no second irq.
3. Src2 qualified faults on 3 consecutive cycles -> recover_req_o=1 the next cycle, recover_src_o=2.
   - Hold ack=0 for 5 cycles -> request holds.
   - ack=1 -> req=0 next cycle.
   - Src2 faults during the following 4 COOL cycles -> counted (cnt2 increments) but no new request.
4. Src0 sequences:
   - fault, valid-low cycle, fault, fault -> request (run holds across invalid cycle).
   - fault, clean valid, fault, fault -> no request.
5. Saturation and clear:
   - 300 qualified faults on src3 -> cnt3=255.
   - clear_i with q[3] the same cycle -> cnt3=1, sticky[3]=1.
   - clear_i alone -> cnt3=0, sticky[3]=0.
6. Src0 and src3 reach run=3 on the same cycle -> recover_src_o=0. recover_ack_i pulsed in IDLE beforehand -> no effect.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared core types for the fault monitor
package cv32e40p_pkg;

    // Escalation state of the fault monitor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } fault_fsm_e;

endpackage

// File: rtl/cv32e40p_fault_monitor_if.sv
// rtl/cv32e40p_fault_monitor_if.sv - fault monitor bus between hardened units/controller and monitor
interface cv32e40p_fault_monitor_if #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]       fault_i;
    logic [N_SRC-1:0]       valid_i;
    logic                   clear_i;
    logic                   recover_ack_i;
    logic [N_SRC-1:0]       fault_sticky_o;
    logic [N_SRC*CNT_W-1:0] fault_cnt_o;
    logic                   recover_req_o;
    logic [SRC_W-1:0]       recover_src_o;
    logic                   irq_o;

    modport master (
        output fault_i, valid_i, clear_i, recover_ack_i,
        input  fault_sticky_o, fault_cnt_o, recover_req_o, recover_src_o, irq_o
    );

    modport slave (
        input  fault_i, valid_i, clear_i, recover_ack_i,
        output fault_sticky_o, fault_cnt_o, recover_req_o, recover_src_o, irq_o
    );

endinterface

// File: rtl/cv32e40p_fault_src_tracker.sv
// rtl/cv32e40p_fault_src_tracker.sv - sticky flag, event counter and persistence run for one source
module cv32e40p_fault_src_tracker #(
    parameter int CNT_W      = 8,
    parameter int PERSIST_TH = 3,
    parameter int RUN_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q,
    input  logic             valid,
    input  logic             fault,
    input  logic             clear,
    input  logic             run_clr,
    input  logic             run_freeze,
    output logic             sticky,
    output logic             sticky_nxt,
    output logic [CNT_W-1:0] cnt,
    output logic [RUN_W-1:0] run_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_TH  = RUN_W'(PERSIST_TH);

    logic [RUN_W-1:0] run;
    logic [CNT_W-1:0] cnt_nxt;

    // Next-state values; a qualified event in a clear cycle survives the clear
    always_comb begin
        sticky_nxt = q | (sticky & ~clear);
        cnt_nxt    = cnt;
        if (clear) begin
            cnt_nxt = q ? CNT_W'(1) : '0;
        end else if (q && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + 1'b1;
        end
        run_nxt = run;
        if (run_clr) begin
            run_nxt = '0;
        end else if (!run_freeze) begin
            if (q) begin
                if (run != RUN_TH) run_nxt = run + 1'b1;
            end else if (valid && !fault) begin
                run_nxt = '0;
            end
        end
    end

    // Per-source state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 1'b0;
            cnt    <= '0;
            run    <= '0;
        end else begin
            sticky <= sticky_nxt;
            cnt    <= cnt_nxt;
            run    <= run_nxt;
        end
    end

endmodule

// File: rtl/cv32e40p_fault_monitor.sv
// rtl/cv32e40p_fault_monitor.sv - fault qualification, status, irq and recovery escalation
module cv32e40p_fault_monitor
    import cv32e40p_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int CNT_W      = 8,
    parameter int PERSIST_TH = 3,
    parameter int COOL_CYC   = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    cv32e40p_fault_monitor_if.slave  bus
);

    localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int RUN_W  = $clog2(PERSIST_TH + 1);
    localparam int COOL_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;

    fault_fsm_e             state;
    logic [COOL_W-1:0]      cool_cnt;
    logic [N_SRC-1:0]       sticky;
    logic [N_SRC-1:0]       sticky_nxt;
    logic [N_SRC-1:0]       hit;
    logic [N_SRC*CNT_W-1:0] cnt;
    logic [SRC_W-1:0]       hit_idx;
    logic [SRC_W-1:0]       src;
    logic                   req;
    logic                   irq;
    logic                   run_clr;
    logic                   run_freeze;

    // Runs hold while a request is outstanding and stay cleared from ack until cooldown ends
    assign run_freeze = (state == REQ);
    assign run_clr    = (state == COOL) || ((state == REQ) && bus.recover_ack_i);

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            logic [RUN_W-1:0] run_nxt;

            cv32e40p_fault_src_tracker #(
                .CNT_W      (CNT_W),
                .PERSIST_TH (PERSIST_TH),
                .RUN_W      (RUN_W)
            ) u_tracker (
                .clk        (clk),
                .rst_n      (rst_n),
                .q          (bus.fault_i[i] & bus.valid_i[i]),
                .valid      (bus.valid_i[i]),
                .fault      (bus.fault_i[i]),
                .clear      (bus.clear_i),
                .run_clr    (run_clr),
                .run_freeze (run_freeze),
                .sticky     (sticky[i]),
                .sticky_nxt (sticky_nxt[i]),
                .cnt        (cnt[i*CNT_W +: CNT_W]),
                .run_nxt    (run_nxt)
            );

            assign hit[i] = (run_nxt == RUN_W'(PERSIST_TH));
        end
    endgenerate

    // Lowest-index persistent source wins
    always_comb begin
        hit_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = SRC_W'(i);
        end
    end

    // One pulse per cycle in which any sticky bit rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(sticky_nxt & ~sticky);
        end
    end

    // Escalation FSM: request on persistence, hold until ack, then cooldown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req      <= 1'b0;
            src      <= '0;
            cool_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|hit) begin
                        state <= REQ;
                        req   <= 1'b1;
                        src   <= hit_idx;
                    end
                end
                REQ: begin
                    if (bus.recover_ack_i) begin
                        state    <= COOL;
                        req      <= 1'b0;
                        cool_cnt <= COOL_W'(COOL_CYC - 1);
                    end
                end
                COOL: begin
                    if (cool_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cool_cnt <= cool_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fault_sticky_o = sticky;
    assign bus.fault_cnt_o    = cnt;
    assign bus.recover_req_o  = req;
    assign bus.recover_src_o  = src;
    assign bus.irq_o          = irq;

endmodule

// File: tb/tb_cv32e40p_fault_monitor.sv
// tb/tb_cv32e40p_fault_monitor.sv - directed-vector bench for the fault monitor
module tb_cv32e40p_fault_monitor;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    cv32e40p_fault_monitor_if #(.N_SRC(4), .CNT_W(8)) bus ();

    cv32e40p_fault_monitor #(
        .N_SRC      (4),
        .CNT_W      (8),
        .PERSIST_TH (3),
        .COOL_CYC   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] cnt_of(input int i);
        return bus.fault_cnt_o[i*8 +: 8];
    endfunction

    // Drive one cycle of inputs at a negedge; return at the next negedge
    task automatic cyc(input logic [3:0] f, input logic [3:0] v, input logic c, input logic a);
        bus.fault_i       = f;
        bus.valid_i       = v;
        bus.clear_i       = c;
        bus.recover_ack_i = a;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.fault_i = '0;
        bus.valid_i = '0;
        bus.clear_i = 1'b0;
        bus.recover_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(4'h0, 4'h0, 0, 0);

        // 1. reset state
        check("rst_sticky", bus.fault_sticky_o, 4'h0);
        check("rst_cnt", bus.fault_cnt_o, 32'h0);
        check("rst_req", bus.recover_req_o, 1'b0);
        check("rst_src", bus.recover_src_o, 2'd0);
        check("rst_irq", bus.irq_o, 1'b0);

        // 2. single multiplier fault, then a repeat
        cyc(4'h2, 4'h2, 0, 0);
        check("t2_sticky", bus.fault_sticky_o, 4'h2);
        check("t2_cnt1", cnt_of(1), 8'd1);
        check("t2_irq", bus.irq_o, 1'b1);
        check("t2_req", bus.recover_req_o, 1'b0);
        cyc(4'h0, 4'h0, 0, 0);
        check("t2_irq_drop", bus.irq_o, 1'b0);
        cyc(4'h2, 4'h2, 0, 0);
        check("t2_cnt1_b", cnt_of(1), 8'd2);
        check("t2_no_irq", bus.irq_o, 1'b0);
        cyc(4'h2, 4'h0, 0, 0);
        check("t2_unqual", cnt_of(1), 8'd2);
        cyc(4'h0, 4'h2, 0, 0);
        check("t2_req_low", bus.recover_req_o, 1'b0);

        // 3. persistent src2 -> request, hold, ack, cooldown
        cyc(4'h4, 4'h4, 0, 0);
        check("t3_irq", bus.irq_o, 1'b1);
        cyc(4'h4, 4'h4, 0, 0);
        check("t3_req_early", bus.recover_req_o, 1'b0);
        cyc(4'h4, 4'h4, 0, 0);
        check("t3_req", bus.recover_req_o, 1'b1);
        check("t3_src", bus.recover_src_o, 2'd2);
        for (int k = 0; k < 5; k++) begin
            cyc(4'h0, 4'h0, 0, 0);
            check("t3_hold_req", bus.recover_req_o, 1'b1);
            check("t3_hold_src", bus.recover_src_o, 2'd2);
        end
        cyc(4'h0, 4'h0, 0, 1);
        check("t3_ack_req", bus.recover_req_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(4'h4, 4'h4, 0, 0);
            check("t3_cool_req", bus.recover_req_o, 1'b0);
            check("t3_cool_cnt2", cnt_of(2), 8'(4 + k));
        end
        cyc(4'h0, 4'h0, 0, 0);
        check("t3_after_req", bus.recover_req_o, 1'b0);
        check("t3_after_cnt2", cnt_of(2), 8'd7);

        // 4a. run holds across a valid-low cycle
        cyc(4'h1, 4'h1, 0, 0);
        cyc(4'h1, 4'h0, 0, 0);
        cyc(4'h1, 4'h1, 0, 0);
        check("t4a_req_early", bus.recover_req_o, 1'b0);
        cyc(4'h1, 4'h1, 0, 0);
        check("t4a_req", bus.recover_req_o, 1'b1);
        check("t4a_src", bus.recover_src_o, 2'd0);
        cyc(4'h0, 4'h0, 0, 1);
        check("t4a_ack", bus.recover_req_o, 1'b0);
        repeat (4) cyc(4'h0, 4'h0, 0, 0);

        // 4b. a clean valid cycle resets the run
        cyc(4'h1, 4'h1, 0, 0);
        cyc(4'h0, 4'h1, 0, 0);
        cyc(4'h1, 4'h1, 0, 0);
        cyc(4'h1, 4'h1, 0, 0);
        cyc(4'h0, 4'h0, 0, 0);
        check("t4b_no_req", bus.recover_req_o, 1'b0);
        cyc(4'h0, 4'h1, 0, 0);

        // 5. saturation, then clear
        for (int k = 0; k < 300; k++) begin
            cyc(4'h8, 4'h8, 0, 0);
            if (k == 253) check("t5_cnt3_254", cnt_of(3), 8'd254);
        end
        check("t5_cnt3_sat", cnt_of(3), 8'd255);
        check("t5_req", bus.recover_req_o, 1'b1);
        check("t5_src", bus.recover_src_o, 2'd3);
        cyc(4'h0, 4'h0, 0, 1);
        repeat (4) cyc(4'h0, 4'h0, 0, 0);
        cyc(4'h8, 4'h8, 1, 0);
        check("t5_clrq_cnt3", cnt_of(3), 8'd1);
        check("t5_clrq_sticky", bus.fault_sticky_o, 4'h8);
        check("t5_clrq_cnt2", cnt_of(2), 8'd0);
        check("t5_clrq_irq", bus.irq_o, 1'b0);
        cyc(4'h0, 4'h0, 1, 0);
        check("t5_clr_cnt3", cnt_of(3), 8'd0);
        check("t5_clr_sticky", bus.fault_sticky_o, 4'h0);
        cyc(4'h0, 4'h8, 0, 0);

        // 6. stray ack in IDLE, then simultaneous src0/src3 persistence
        cyc(4'h0, 4'h0, 0, 1);
        check("t6_stray_ack", bus.recover_req_o, 1'b0);
        cyc(4'h9, 4'h9, 0, 0);
        check("t6_irq_one", bus.irq_o, 1'b1);
        check("t6_sticky", bus.fault_sticky_o, 4'h9);
        cyc(4'h9, 4'h9, 0, 0);
        check("t6_irq_drop", bus.irq_o, 1'b0);
        cyc(4'h9, 4'h9, 0, 0);
        check("t6_req", bus.recover_req_o, 1'b1);
        check("t6_src", bus.recover_src_o, 2'd0);

        // 1b. asynchronous reset while in REQ
        bus.fault_i = '0;
        bus.valid_i = '0;
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_req", bus.recover_req_o, 1'b0);
        check("t1_async_sticky", bus.fault_sticky_o, 4'h0);
        check("t1_async_cnt", bus.fault_cnt_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'h0, 4'h0, 0, 0);
        check("t1_post_req", bus.recover_req_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
